// File: rtl/hamming_gen.sv
// Streaming Hamming line/column parity generator for one sector of bytes.
// Produces the 2*(SECTOR_AW+3)-bit ECC word that the syndrome checker consumes.
module hamming_gen #(
    parameter int unsigned SECTOR_AW = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ecc_start,
    input  logic                           data_valid,
    input  logic [7:0]                     data_in,
    output logic                           busy,
    output logic                           ecc_valid,
    output logic [2*(SECTOR_AW+3)-1:0]     ecc_out
);

    localparam int unsigned ECC_W  = 2 * (SECTOR_AW + 3);
    localparam int unsigned LINE_W = 2 * SECTOR_AW;
    localparam int unsigned COL_W  = 6;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_e;

    state_e                 state_q;
    logic [ECC_W-1:0]       acc_q;
    logic [ECC_W-1:0]       acc_d;
    logic [SECTOR_AW-1:0]   byte_cnt_q;
    logic [SECTOR_AW-1:0]   byte_cnt_d;
    logic [COL_W-1:0]       col_par;
    logic [LINE_W-1:0]      line_par;
    logic                   byte_par;
    logic                   last_byte;

    // Column parity: odd bit of each pair covers bit indices with that address bit set.
    assign col_par[1] = ^(data_in & 8'hAA);
    assign col_par[0] = ^(data_in & 8'h55);
    assign col_par[3] = ^(data_in & 8'hCC);
    assign col_par[2] = ^(data_in & 8'h33);
    assign col_par[5] = ^(data_in & 8'hF0);
    assign col_par[4] = ^(data_in & 8'h0F);

    assign byte_par = ^data_in;

    // Line parity: the whole-byte parity lands in the odd or even slot per byte-index bit.
    for (genvar k = 0; k < SECTOR_AW; k++) begin : g_line
        assign line_par[2*k+1] = byte_par &  byte_cnt_q[k];
        assign line_par[2*k]   = byte_par & ~byte_cnt_q[k];
    end

    assign acc_d      = acc_q ^ {line_par, col_par};
    assign byte_cnt_d = byte_cnt_q + SECTOR_AW'(1);
    assign last_byte  = (byte_cnt_q == '1);

    // Sector FSM with registered busy/ecc_valid/ecc_out; start always wins over data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            byte_cnt_q <= '0;
            busy       <= 1'b0;
            ecc_valid  <= 1'b0;
            ecc_out    <= '0;
        end else begin
            ecc_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ecc_start) begin
                        state_q    <= S_ACCUM;
                        acc_q      <= '0;
                        byte_cnt_q <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (ecc_start) begin
                        acc_q      <= '0;
                        byte_cnt_q <= '0;
                    end else if (data_valid) begin
                        if (last_byte) begin
                            ecc_out    <= acc_d;
                            ecc_valid  <= 1'b1;
                            busy       <= 1'b0;
                            state_q    <= S_IDLE;
                            acc_q      <= '0;
                            byte_cnt_q <= '0;
                        end else begin
                            acc_q      <= acc_d;
                            byte_cnt_q <= byte_cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_gen.sv
// Self-checking bench for hamming_gen: bit-address reference model feeding a
// scoreboard queue, plus directed checks on latency, busy, restart and reset.
module tb_hamming_gen;

    localparam int unsigned SECTOR_AW = 9;
    localparam int unsigned N_BYTES   = 1 << SECTOR_AW;
    localparam int unsigned AW        = SECTOR_AW + 3;
    localparam int unsigned ECC_W     = 2 * AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             ecc_start;
    logic             data_valid;
    logic [7:0]       data_in;
    logic             busy;
    logic             ecc_valid;
    logic [ECC_W-1:0] ecc_out;

    hamming_gen #(.SECTOR_AW(SECTOR_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ecc_start  (ecc_start),
        .data_valid (data_valid),
        .data_in    (data_in),
        .busy       (busy),
        .ecc_valid  (ecc_valid),
        .ecc_out    (ecc_out)
    );

    always #5 clk = ~clk;

    int               n_tests  = 0;
    int               n_fail   = 0;
    int               n_valid  = 0;
    int               busy_low = 0;
    logic             prev_valid = 1'b0;
    logic [ECC_W-1:0] exp_q[$];
    logic [7:0]       sec [N_BYTES];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference straight from the bit-address definition of each parity bit.
    function automatic logic [ECC_W-1:0] ref_ecc();
        logic [ECC_W-1:0] e;
        logic [AW-1:0]    a;
        e = '0;
        for (int b = 0; b < N_BYTES; b++) begin
            for (int i = 0; i < 8; i++) begin
                if (sec[b][i]) begin
                    a = AW'(b * 8 + i);
                    for (int k = 0; k < AW; k++) e[2*k + int'(a[k])] ^= 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int b = 0; b < N_BYTES; b++) sec[b] = v;
    endtask

    task automatic fill_rand();
        for (int b = 0; b < N_BYTES; b++) sec[b] = 8'($urandom);
    endtask

    task automatic check_syndrome(input string tag, input logic [ECC_W-1:0] stored,
                                  input logic [ECC_W-1:0] got, input int addr);
        logic [ECC_W-1:0] syn;
        int               loc;
        syn = stored ^ got;
        loc = 0;
        for (int k = 0; k < AW; k++) if (syn[2*k+1]) loc |= (1 << k);
        check_eq({tag, "_ones"}, 32'($countones(syn)), 32'd12);
        check_eq({tag, "_addr"}, 32'(loc), 32'(addr));
    endtask

    // All drive tasks enter and leave 1 time unit after a rising edge.
    task automatic do_start(input logic with_data, input logic [7:0] junk);
        ecc_start  = 1'b1;
        data_valid = with_data;
        data_in    = junk;
        @(posedge clk); #1;
        ecc_start  = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic feed(input int first, input int last, input int max_gap);
        for (int b = first; b <= last; b++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    data_valid = 1'b0;
                    if (!busy) busy_low++;
                    @(posedge clk); #1;
                end
            end
            data_valid = 1'b1;
            data_in    = sec[b];
            if (!busy) busy_low++;
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
    endtask

    task automatic run_sector(input string tag, input int max_gap, input logic [ECC_W-1:0] exp_const,
                              input logic start_with_data, input logic [7:0] junk);
        busy_low = 0;
        exp_q.push_back(ref_ecc());
        do_start(start_with_data, junk);
        feed(0, N_BYTES - 1, max_gap);
        check_eq({tag, "_valid"},     32'(ecc_valid), 32'd1);
        check_eq({tag, "_busy_fall"}, 32'(busy),      32'd0);
        check_eq({tag, "_busy_cont"}, 32'(busy_low),  32'd0);
        check_eq({tag, "_ecc"},       32'(ecc_out),   32'(exp_const));
    endtask

    // Scoreboard: every completion pops one expected word; pulses must be single-cycle.
    always @(negedge clk) begin
        if (!rst && ecc_valid) begin
            n_valid++;
            check_eq("valid_width", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            else                   check_eq("sb_ecc", 32'(ecc_out), 32'(exp_q.pop_front()));
        end
        prev_valid = ecc_valid;
    end

    initial begin
        int               n0;
        int               fb;
        int               fi;
        logic [ECC_W-1:0] stored;

        rst = 1'b1; ecc_start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk); #1;
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_valid", 32'(ecc_valid), 32'd0);
        check_eq("rst_ecc",   32'(ecc_out),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill_const(8'h00); sec[0] = 8'h01;
        run_sector("addr0", 0, 24'h555555, 1'b0, 8'h00);

        // Reset mid-sector must clear outputs at once and never complete.
        fill_rand();
        do_start(1'b0, 8'h00);
        feed(0, 99, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_busy",  32'(busy),      32'd0);
        check_eq("midrst_valid", 32'(ecc_valid), 32'd0);
        check_eq("midrst_ecc",   32'(ecc_out),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = n_valid;
        fill_const(8'h00);
        run_sector("zero", 0, 24'h000000, 1'b0, 8'h00);
        repeat (3) @(posedge clk); #1;
        check_eq("zero_pulses", 32'(n_valid - n0), 32'd1);

        fill_const(8'h00); sec[N_BYTES-1] = 8'h80;
        run_sector("top", 0, 24'hAAAAAA, 1'b0, 8'h00);

        fill_const(8'h00); sec[5] = 8'h08;
        run_sector("b5", 0, 24'h55599A, 1'b0, 8'h00);
        check_syndrome("b5_syn", 24'h000000, ecc_out, 32'h02B);

        fill_const(8'hFF);
        run_sector("ff_gaps", 3, 24'h000000, 1'b0, 8'h00);

        // Bytes presented while idle must be ignored.
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            data_valid = 1'b1; data_in = 8'($urandom);
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        check_eq("idle_busy", 32'(busy), 32'd0);

        fill_rand();
        stored = ref_ecc();
        run_sector("rand", 2, stored, 1'b0, 8'h00);

        // Single-bit corruption, started in the same cycle the previous ecc_valid is high.
        fb = int'($urandom_range(N_BYTES - 1, 0));
        fi = int'($urandom_range(7, 0));
        sec[fb][fi] = ~sec[fb][fi];
        run_sector("flip", 1, ref_ecc(), 1'b0, 8'h00);
        check_syndrome("flip_syn", stored, ecc_out, fb * 8 + fi);

        // Restart at byte 300; the restart beat carries data that must be dropped.
        @(posedge clk); #1;
        n0 = n_valid;
        fill_rand();
        do_start(1'b0, 8'h00);
        feed(0, 299, 1);
        fill_const(8'h00); sec[0] = 8'h01;
        run_sector("restart", 0, 24'h555555, 1'b1, 8'h80);
        repeat (3) @(posedge clk); #1;
        check_eq("restart_pulses", 32'(n_valid - n0), 32'd1);

        repeat (4) @(posedge clk); #1;
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
